eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
- Shares the single TX datapath of the tri-speed Ethernet MAC between NUM_PORTS upper-layer frame sources (e.g. ARP, IPv4, raw/debug).
- Grants one source at a time, round-robin, only when the MAC reports tx_ready.
- Forwards the granted source's start/data_valid/data byte stream to the MAC with a one-cycle register stage.
- Releases the grant when the MAC has finished the frame and its IFG.
- Sits in the GMII TX clock domain between protocol engines and the MAC.

Parameters:
NUM_PORTS, 4, number of requesters (legal 2..8)
START_TIMEOUT, 15, cycles a granted port may wait before asserting start (legal 1..255)

Ports:
clk  in  1  GMII TX clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_PORTS  per-port request; a frame is fully buffered and ready to stream
grant  out  NUM_PORTS  one-hot grant (all zero when none)
src_start  in  NUM_PORTS  per-port frame start strobe
src_data_valid  in  NUM_PORTS  per-port byte-valid strobe
src_data  in  NUM_PORTS*8  per-port data byte, port i at [8i+7:8i]
mac_tx_ready  in  1  MAC ready for next frame
mac_tx_start  out  1  forwarded start
mac_tx_data_valid  out  1  forwarded byte valid
mac_tx_data  out  8  forwarded byte
active_port  out  3  index of granted port (valid while grant != 0)
timeout  out  1  one-cycle pulse: granted port failed to start in time
protocol_error  out  1  one-cycle pulse: start from granted port while in BUSY

Behaviour:
- Reset values:
  - grant=0, mac_tx_start=0, mac_tx_data_valid=0, mac_tx_data=0, active_port=0, timeout=0, protocol_error=0.
  - State=IDLE, rr pointer=0, timer=0.
- States:
  - IDLE:
    - If mac_tx_ready and req != 0: pick the first set req bit searching upward from the rr pointer, wrapping modulo NUM_PORTS.
    - Assert grant one-hot and set active_port the next cycle; timer=0; go to WAIT_START.
    - Otherwise stay in IDLE.
  - WAIT_START:
    - timer increments every cycle.
    - If src_start[active_port]: forward it and go to BUSY with seen_busy=0.
    - Else if req[active_port] drops: release grant, go to IDLE; rr pointer unchanged.
    - Else if timer == START_TIMEOUT-1: pulse timeout, release grant, set rr pointer=active_port+1 (mod NUM_PORTS), go to IDLE.
  - BUSY:
    - Set seen_busy when mac_tx_ready==0.
    - When seen_busy and mac_tx_ready==1: release grant, set rr pointer=active_port+1 (mod NUM_PORTS), go to IDLE.
    - req is ignored in BUSY.
    - A further src_start[active_port] is not forwarded; it pulses protocol_error.
- Forwarding:
  - mac_tx_* register the granted port's inputs, so latency is exactly 1 cycle.
  - Only in WAIT_START (start and data) and BUSY (data only). In all other cases the outputs register 0.
  - Inputs from non-granted ports are ignored entirely.
  - data_valid bytes are forwarded without gaps checking; the source owns contiguity.
- Grant release occurs on the same edge the state leaves BUSY. A new grant needs at least one cycle in IDLE, so there is at least 1 cycle with grant=0 between frames.
- Simultaneous src_start and timeout expiry: start wins.
- Simultaneous req drop and src_start: start wins.
- Reset asserted mid-frame: outputs clear immediately. A frame already partially sent is abandoned; the MAC pads/ends it on its own.

Optional Feature:
- Macro ETH_TX_ARB_PERF_EN.
- Defined: adds outputs perf_frames (NUM_PORTS*32) and perf_timeouts (32).
  - perf_frames[i] increments once per forwarded start from port i.
  - perf_timeouts increments on each timeout pulse.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: these ports still exist but are tied to 0, and no counter logic is generated.

Decomposition:
- Package eth_tx_arb_pkg:
  - State enum (IDLE=0, WAIT_START=1, BUSY=2).
  - PORT_IDX_WIDTH=3.
  - Timer width 8.
- Sub-module rr_picker: combinational; inputs req and pointer; outputs found plus index of the first set bit at or after the pointer, with wrap. It is reused by future RX-side schedulers.

Test Plan:
- Single request: req=0001, mac_tx_ready=1 → grant=0001 one cycle later. Port 0 sends start plus 60 bytes → identical stream on mac_tx_* delayed 1 cycle. Grant drops on the first cycle mac_tx_ready returns high.
- Round-robin: req=1111 held over 5 frames → grant order is ports 0,1,2,3,0.
- Timeout: req=0010 with no start → timeout pulses at START_TIMEOUT cycles after grant (15). Next grant goes to the next requesting port, with port 1 skipped if another port requests.
- Isolation: port 2 toggles start/data while port 0 is granted → mac_tx_* carries only port 0 traffic. A second start from port 0 during BUSY → protocol_error=1 for one cycle and no forwarded start.
- Reset mid-BUSY → all outputs 0 next cycle. After release, req=0100 with mac_tx_ready=1 is granted normally.
- With ETH_TX_ARB_PERF_EN: 3 frames from port 1 and 1 timeout → perf_frames[63:32]=3, perf_timeouts=1.

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet TX arbiter and its round-robin picker.
package eth_tx_arb_pkg;

  localparam int PORT_IDX_WIDTH = 3;
  localparam int TIMER_WIDTH    = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE       = 2'd0;
  localparam arb_state_t ST_WAIT_START = 2'd1;
  localparam arb_state_t ST_BUSY       = 2'd2;

  // Port index + 1, wrapping at num_ports.
  function automatic logic [PORT_IDX_WIDTH-1:0] wrap_inc(
    input logic [PORT_IDX_WIDTH-1:0] idx,
    input int                        num_ports
  );
    if (int'(idx) >= num_ports - 1) return '0;
    return idx + PORT_IDX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or after pointer, wrapping.
module rr_picker
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [PORT_IDX_WIDTH-1:0] pointer,
  output logic                      found,
  output logic [PORT_IDX_WIDTH-1:0] index
);

  int cand;

  // Scan farthest candidate first so the nearest one overwrites and wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = int'(pointer) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[i] && (cand == i)) begin
          found = 1'b1;
          index = PORT_IDX_WIDTH'(i);
        end
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the MAC TX datapath between NUM_PORTS frame sources.
// Optional macro ETH_TX_ARB_PERF_EN enables the perf_frames/perf_timeouts counters.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req,
  output logic [NUM_PORTS-1:0]      grant,
  input  logic [NUM_PORTS-1:0]      src_start,
  input  logic [NUM_PORTS-1:0]      src_data_valid,
  input  logic [NUM_PORTS*8-1:0]    src_data,
  input  logic                      mac_tx_ready,
  output logic                      mac_tx_start,
  output logic                      mac_tx_data_valid,
  output logic [7:0]                mac_tx_data,
  output logic [PORT_IDX_WIDTH-1:0] active_port,
  output logic                      timeout,
  output logic                      protocol_error,
  output logic [NUM_PORTS*32-1:0]   perf_frames,
  output logic [31:0]               perf_timeouts
);

  arb_state_t                state;
  logic [PORT_IDX_WIDTH-1:0] rr_ptr;
  logic [TIMER_WIDTH-1:0]    timer;
  logic                      seen_busy;

  logic                      pick_found;
  logic [PORT_IDX_WIDTH-1:0] pick_idx;
  logic [NUM_PORTS-1:0]      pick_onehot;
  logic                      sel_req;
  logic                      sel_start;
  logic                      sel_dv;
  logic [7:0]                sel_data;
  logic [PORT_IDX_WIDTH-1:0] next_ptr;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req     (req),
    .pointer (rr_ptr),
    .found   (pick_found),
    .index   (pick_idx)
  );

  assign next_ptr = wrap_inc(active_port, NUM_PORTS);

  always_comb begin
    sel_req     = 1'b0;
    sel_start   = 1'b0;
    sel_dv      = 1'b0;
    sel_data    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (active_port == PORT_IDX_WIDTH'(i)) begin
        sel_req   = req[i];
        sel_start = src_start[i];
        sel_dv    = src_data_valid[i];
        sel_data  = src_data[i*8 +: 8];
      end
      if (pick_idx == PORT_IDX_WIDTH'(i)) pick_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      rr_ptr            <= '0;
      timer             <= '0;
      seen_busy         <= 1'b0;
      grant             <= '0;
      active_port       <= '0;
      mac_tx_start      <= 1'b0;
      mac_tx_data_valid <= 1'b0;
      mac_tx_data       <= '0;
      timeout           <= 1'b0;
      protocol_error    <= 1'b0;
    end else begin
      timeout           <= 1'b0;
      protocol_error    <= 1'b0;
      mac_tx_start      <= 1'b0;
      mac_tx_data_valid <= 1'b0;
      mac_tx_data       <= '0;
      case (state)
        ST_IDLE: begin
          if (mac_tx_ready && pick_found) begin
            grant       <= pick_onehot;
            active_port <= pick_idx;
            timer       <= '0;
            state       <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          timer             <= timer + TIMER_WIDTH'(1);
          mac_tx_start      <= sel_start;
          mac_tx_data_valid <= sel_dv;
          mac_tx_data       <= sel_data;
          // Start has priority over both a dropped request and timer expiry.
          if (sel_start) begin
            seen_busy <= 1'b0;
            state     <= ST_BUSY;
          end else if (!sel_req) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (timer == TIMER_WIDTH'(START_TIMEOUT - 1)) begin
            timeout <= 1'b1;
            grant   <= '0;
            rr_ptr  <= next_ptr;
            state   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          mac_tx_data_valid <= sel_dv;
          mac_tx_data       <= sel_data;
          if (sel_start) protocol_error <= 1'b1;
          // The frame is done only after the MAC has dropped ready and raised it again.
          if (!mac_tx_ready) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ETH_TX_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_frames   <= '0;
      perf_timeouts <= '0;
    end else begin
      // active_port is still stable on the cycle the forwarded start appears.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mac_tx_start && (active_port == PORT_IDX_WIDTH'(i)))
          perf_frames[i*32 +: 32] <= perf_frames[i*32 +: 32] + 32'd1;
      end
      if (timeout) perf_timeouts <= perf_timeouts + 32'd1;
    end
  end
`else
  assign perf_frames   = '0;
  assign perf_timeouts = '0;
`endif

endmodule
